// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory responder.
// FSM encoding, wait-state limit and IO register reset value.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int WAIT_MAX = 15;
  localparam logic [31:0] IO_RST = 32'h0000_0000;

endpackage

// File: rtl/dmem_if.sv
// dmem_if: MEM-stage <-> data-memory request/response bundle.
// master = MEM stage, slave = memory responder.
interface dmem_if;

  logic        MemRead;
  logic        MemWrite;
  logic        IOInst;
  logic [31:0] Addr;
  logic [31:0] Wdata;
  logic [31:0] Rdata;
  logic        Ready;
  logic        AddrErr;
  logic        Busy;

  modport master (
    output MemRead, MemWrite, IOInst, Addr, Wdata,
    input  Rdata, Ready, AddrErr, Busy
  );

  modport slave (
    input  MemRead, MemWrite, IOInst, Addr, Wdata,
    output Rdata, Ready, AddrErr, Busy
  );

endinterface

// File: rtl/dmem_ram.sv
// dmem_ram: single-port synchronous word RAM, registered read.
// Written so synthesis maps it onto a block RAM.
module dmem_ram
  import dmem_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       din,
  output logic [31:0]       dout
);

  logic [31:0] mem [DEPTH];

  // write port plus registered read (old data on collision)
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
    dout <= mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: wait-stated data-memory responder with IO register.
// DMEM_WRITE_FWD_EN adds a store->load bypass register.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic   clk,
  input  logic   rst,
  dmem_if.slave  bus
);

  localparam int WC = (WAIT_CYCLES > WAIT_MAX) ? WAIT_MAX : WAIT_CYCLES;
  localparam logic [3:0] WC4 = 4'(WC);

  state_t state, stateNxt;
  logic [3:0] cnt, cntNxt;
  logic [31:0] addrQ, wdataQ, rdataQ, ioReg;
  logic readQ, writeQ, ioQ, errQ;
  logic [31:0] curAddr, curWdata;
  logic curRead, curWrite, curIO;
  logic req, accept, enterResp;
  logic misal, outRange, bothOp, err, ramWe;
  logic [ADDR_W-1:0] ramAddr;
  logic [31:0] ramDout, loadData, respData;

  assign req = bus.MemRead | bus.MemWrite;

  // live inputs while idle, latched request once accepted
  always_comb begin
    curAddr  = addrQ;
    curWdata = wdataQ;
    curRead  = readQ;
    curWrite = writeQ;
    curIO    = ioQ;
    if (state == IDLE) begin
      curAddr  = bus.Addr;
      curWdata = bus.Wdata;
      curRead  = bus.MemRead;
      curWrite = bus.MemWrite;
      curIO    = bus.IOInst;
    end
  end

  assign misal    = curAddr[1:0] != 2'b00;
  assign outRange = !curIO && (curAddr[31:ADDR_W+2] != '0);
  assign bothOp   = curRead && curWrite;
  assign err      = misal | outRange | bothOp;
  assign ramAddr  = curAddr[ADDR_W+1:2];
  assign ramWe    = enterResp && curWrite && !curIO && !err;

  // next-state and wait counter
  always_comb begin
    stateNxt  = state;
    cntNxt    = cnt;
    accept    = 1'b0;
    enterResp = 1'b0;
    unique case (state)
      IDLE: if (req) begin
        accept = 1'b1;
        if (WC == 0) begin
          stateNxt  = RESP;
          enterResp = 1'b1;
        end else begin
          stateNxt = WAIT;
          cntNxt   = WC4;
        end
      end
      WAIT: if (cnt <= 4'd1) begin
        stateNxt  = RESP;
        enterResp = 1'b1;
        cntNxt    = 4'd0;
      end else begin
        cntNxt = cnt - 4'd1;
      end
      RESP: stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  // state, counter and request latches
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      addrQ  <= '0;
      wdataQ <= '0;
      readQ  <= 1'b0;
      writeQ <= 1'b0;
      ioQ    <= 1'b0;
    end else begin
      state <= stateNxt;
      cnt   <= cntNxt;
      if (accept) begin
        addrQ  <= bus.Addr;
        wdataQ <= bus.Wdata;
        readQ  <= bus.MemRead;
        writeQ <= bus.MemWrite;
        ioQ    <= bus.IOInst;
      end
    end
  end

  // response status, IO register and held load data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      errQ   <= 1'b0;
      ioReg  <= IO_RST;
      rdataQ <= '0;
    end else begin
      if (enterResp) errQ <= err;
      if (enterResp && curWrite && curIO && !err)
        ioReg <= curWdata;
      if (state == RESP && readQ)
        rdataQ <= respData;
    end
  end

  dmem_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) uRam (
    .clk  (clk),
    .we   (ramWe),
    .addr (ramAddr),
    .din  (curWdata),
    .dout (ramDout)
  );

`ifdef DMEM_WRITE_FWD_EN
  logic              fwdValid;
  logic [ADDR_W-1:0] fwdIdx;
  logic [31:0]       fwdData;

  // remember the last committed store word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwdValid <= 1'b0;
      fwdIdx   <= '0;
      fwdData  <= '0;
    end else if (ramWe) begin
      fwdValid <= 1'b1;
      fwdIdx   <= ramAddr;
      fwdData  <= curWdata;
    end
  end

  assign loadData =
    (fwdValid && fwdIdx == addrQ[ADDR_W+1:2]) ? fwdData : ramDout;
`else
  assign loadData = ramDout;
`endif

  assign respData = errQ ? 32'h0 : (ioQ ? ioReg : loadData);

  assign bus.Ready   = (state == RESP);
  assign bus.AddrErr = (state == RESP) && errQ;
  assign bus.Busy    = (state != IDLE);
  assign bus.Rdata   = (state == RESP && readQ) ? respData : rdataQ;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks on two responders (1 and 0 wait states).
// Instance 0 uses WAIT_CYCLES=1, instance 1 uses WAIT_CYCLES=0.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  dmem_if ifA ();
  dmem_if ifB ();

  logic [1:0]  mr, mw, mio;
  logic [31:0] ma [2];
  logic [31:0] mwd [2];
  logic [1:0]  rdyV, errV, busyV;
  logic [31:0] rdataV [2];

  assign ifA.MemRead  = mr[0];
  assign ifA.MemWrite = mw[0];
  assign ifA.IOInst   = mio[0];
  assign ifA.Addr     = ma[0];
  assign ifA.Wdata    = mwd[0];
  assign ifB.MemRead  = mr[1];
  assign ifB.MemWrite = mw[1];
  assign ifB.IOInst   = mio[1];
  assign ifB.Addr     = ma[1];
  assign ifB.Wdata    = mwd[1];

  assign rdyV[0]   = ifA.Ready;
  assign rdyV[1]   = ifB.Ready;
  assign errV[0]   = ifA.AddrErr;
  assign errV[1]   = ifB.AddrErr;
  assign busyV[0]  = ifA.Busy;
  assign busyV[1]  = ifB.Busy;
  assign rdataV[0] = ifA.Rdata;
  assign rdataV[1] = ifB.Rdata;

  dmem_responder #(.WAIT_CYCLES(1)) dutA (
    .clk (clk),
    .rst (rst),
    .bus (ifA)
  );

  dmem_responder #(.WAIT_CYCLES(0)) dutB (
    .clk (clk),
    .rst (rst),
    .bus (ifB)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  // lat = index of the edge (0 = first edge after driving) after
  // which Ready is seen; returns at the negedge of the Ready cycle
  task automatic acc(input int d, input bit rdb, input bit wrb,
                     input bit iob, input logic [31:0] a,
                     input logic [31:0] wd, input bit now,
                     input bit keep, output logic [31:0] rdat,
                     output logic aerr, output int lat);
    if (!now) begin
      @(posedge clk);
      #1;
    end
    mr[d] = rdb;
    mw[d] = wrb;
    mio[d] = iob;
    ma[d] = a;
    mwd[d] = wd;
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (rdyV[d]) begin
        lat = k;
        break;
      end
    end
    rdat = rdataV[d];
    aerr = errV[d];
    if (!keep) begin
      mr[d] = 1'b0;
      mw[d] = 1'b0;
    end
    if (lat < 0) chk("timeout", 32'(lat), 32'd0);
  endtask

  initial begin
    logic [31:0] d;
    logic e;
    int lat;
    int t0;
    mr = '0;
    mw = '0;
    mio = '0;
    ma[0] = '0;
    ma[1] = '0;
    mwd[0] = '0;
    mwd[1] = '0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_rdata", rdataV[0], 32'h0);
    chk("rst_ready", 32'(rdyV[0]), 32'd0);
    chk("rst_busy", 32'(busyV[0]), 32'd0);
    chk("rst_err", 32'(errV[0]), 32'd0);
    chk("rst_busyB", 32'(busyV[1]), 32'd0);

    // store then load, one wait state: Ready after edge 1
    acc(0, 0, 1, 0, 32'h10, 32'hDEADBEEF, 0, 0, d, e, lat);
    chk("st_lat", 32'(lat), 32'd1);
    chk("st_err", 32'(e), 32'd0);
    acc(0, 1, 0, 0, 32'h10, 32'h0, 0, 0, d, e, lat);
    chk("ld_data", d, 32'hDEADBEEF);
    chk("ld_err", 32'(e), 32'd0);
    chk("ld_lat", 32'(lat), 32'd1);

    // misaligned store: rejected, Rdata left from last load
    acc(0, 0, 1, 0, 32'h13, 32'hFFFF0000, 0, 0, d, e, lat);
    chk("mis_err", 32'(e), 32'd1);
    chk("mis_rdata", d, 32'hDEADBEEF);
    acc(0, 1, 1, 0, 32'h10, 32'h0, 0, 0, d, e, lat);
    chk("both_err", 32'(e), 32'd1);
    acc(0, 1, 0, 0, 32'h10, 32'h0, 0, 0, d, e, lat);
    chk("ram_keep", d, 32'hDEADBEEF);
    acc(0, 1, 0, 0, 32'h400, 32'h0, 0, 0, d, e, lat);
    chk("oor_err", 32'(e), 32'd1);
    chk("oor_data", d, 32'h0);

    // IO register: address ignored for range, RAM untouched
    acc(0, 0, 1, 1, 32'h10, 32'hA5, 0, 0, d, e, lat);
    chk("io_st_err", 32'(e), 32'd0);
    acc(0, 1, 0, 1, 32'hFFFFFFF0, 32'h0, 0, 0, d, e, lat);
    chk("io_ld", d, 32'hA5);
    chk("io_ld_err", 32'(e), 32'd0);
    acc(0, 1, 0, 0, 32'h10, 32'h0, 0, 0, d, e, lat);
    chk("io_ram_keep", d, 32'hDEADBEEF);

    // reset during WAIT aborts the store
    acc(0, 0, 1, 0, 32'h40, 32'h11, 0, 0, d, e, lat);
    @(posedge clk);
    #1;
    mw[0] = 1'b1;
    ma[0] = 32'h40;
    mwd[0] = 32'h55;
    @(posedge clk);
    #1;
    chk("mid_busy", 32'(busyV[0]), 32'd1);
    rst = 1'b1;
    mw[0] = 1'b0;
    e = 1'b0;
    repeat (3) begin
      @(negedge clk);
      e = e | rdyV[0];
    end
    chk("mid_noready", 32'(e), 32'd0);
    rst = 1'b0;
    acc(0, 1, 0, 0, 32'h40, 32'h0, 0, 0, d, e, lat);
    chk("mid_nowrite", d, 32'h11);
    chk("mid_lat", 32'(lat), 32'd1);
    acc(0, 1, 0, 1, 32'h0, 32'h0, 0, 0, d, e, lat);
    chk("io_rst", d, 32'h0);

    // zero wait states: back-to-back loads every 2 cycles
    acc(1, 0, 1, 0, 32'h0, 32'h1, 0, 0, d, e, lat);
    acc(1, 0, 1, 0, 32'h4, 32'h2, 0, 0, d, e, lat);
    acc(1, 0, 1, 0, 32'h8, 32'h3, 0, 0, d, e, lat);
    acc(1, 1, 0, 0, 32'h0, 32'h0, 0, 0, d, e, lat);
    chk("bb0", d, 32'h1);
    chk("bb0_lat", 32'(lat), 32'd0);
    t0 = cyc;
    acc(1, 1, 0, 0, 32'h4, 32'h0, 0, 0, d, e, lat);
    chk("bb1", d, 32'h2);
    chk("bb1_gap", 32'(cyc - t0), 32'd2);
    t0 = cyc;
    acc(1, 1, 0, 0, 32'h8, 32'h0, 0, 0, d, e, lat);
    chk("bb2", d, 32'h3);
    chk("bb2_gap", 32'(cyc - t0), 32'd2);

    // request held across Ready: next access taken in the IDLE cycle
    acc(0, 0, 1, 0, 32'h20, 32'h1234, 0, 1, d, e, lat);
    chk("held_st_err", 32'(e), 32'd0);
    acc(0, 1, 0, 0, 32'h20, 32'h0, 1, 0, d, e, lat);
    chk("held_ld", d, 32'h1234);
    chk("held_lat", 32'(lat), 32'd2);
    acc(1, 0, 1, 0, 32'h20, 32'h5678, 0, 1, d, e, lat);
    acc(1, 1, 0, 0, 32'h20, 32'h0, 1, 0, d, e, lat);
    chk("heldB_ld", d, 32'h5678);
    chk("heldB_lat", 32'(lat), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
